enc64to6_stream: RTL



---
 rtl/enc64to6_stream.sv | 112 +++++++++++
 1 files changed

// File: rtl/enc64to6_stream.sv
// Sequential 64-to-6 encoder: latches a state-flag vector and streams the index
// of every set bit, lowest first, one per accepted beat.
module enc64to6_stream (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] in,
    input  logic        clear,
    output logic [5:0]  out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        last,
    output logic        busy,
    output logic        empty,
    output logic [6:0]  count
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_p0, state_nx;
    logic [63:0] mask_p0, mask_nx;
    logic [6:0]  count_p0, count_nx;
    logic        empty_p0, empty_nx;
    logic        scanning;
    logic [5:0]  low_idx;
    logic        one_left;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] acc;
        acc = '0;
        for (int i = 0; i < 64; i++) begin
            acc = acc + 7'(v[i]);
        end
        return acc;
    endfunction

    // Scan from the top down so the lowest set bit is the last one written.
    function automatic logic [5:0] lowest_idx(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) begin
                idx = 6'(i);
            end
        end
        return idx;
    endfunction

    assign scanning  = (state_p0 == SCAN);
    assign low_idx   = lowest_idx(mask_p0);
    assign one_left  = ((mask_p0 & (mask_p0 - 64'd1)) == '0);

    assign out       = scanning ? low_idx : 6'd0;
    assign out_valid = scanning;
    assign last      = scanning & one_left;
    assign busy      = scanning;
    assign empty     = empty_p0;
    assign count     = count_p0;

    always_comb begin
        state_nx = state_p0;
        mask_nx  = mask_p0;
        count_nx = count_p0;
        empty_nx = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            mask_nx  = '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (load) begin
                        count_nx = popcount64(in);
                        if (in != '0) begin
                            mask_nx  = in;
                            state_nx = SCAN;
                        end else begin
                            empty_nx = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        // Dropping the lowest set bit leaves zero after the last beat.
                        mask_nx = mask_p0 & (mask_p0 - 64'd1);
                        if (one_left) begin
                            state_nx = IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    mask_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
            mask_p0  <= '0;
            count_p0 <= '0;
            empty_p0 <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            mask_p0  <= mask_nx;
            count_p0 <= count_nx;
            empty_p0 <= empty_nx;
        end
    end

endmodule
